seq_hit_counter: RTL and testbench
==================================

// Module: seq_hit_counter
// PURPOSE
//  Downstream consumer of the serial sequence detector. Takes the detector's per-match
//  pulse and counts matches in two-digit BCD (00-99). Provides a sticky overflow flag and
//  clear/hold controls. Drives a 2-digit multiplexed active-low 7-segment display so match
//  counts are visible on the board during the lab.
// PARAMETERS
//  SCAN_DIV  16  clock cycles each digit is lit before the scan moves on (legal range >= 2)
// PORTS
//  c          in   1  clock; all state updates on rising edge
//  res        in   1  reset, synchronous, active-low
//  hit        in   1  detector match output; level or pulse, counted on its rising edge
//  clr        in   1  synchronous count clear, active-high
//  hold       in   1  freeze count while high, active-high
//  ones       out  4  BCD units digit
//  tens       out  4  BCD tens digit
//  ovf        out  1  sticky overflow flag (100th hit seen)
//  seg        out  7  active-low segments {g,f,e,d,c,b,a}
//  an         out  2  active-low digit enables: an[0] = units, an[1] = tens
//  st         out  2  FSM state for debug: 00 RUN, 01 HOLD, 10 OVF
// BEHAVIOUR
//  - Reset (res=0 at an edge) sets: ones=0, tens=0, ovf=0, st=RUN, hit_q=0, scan cnt=0,
//    an=2'b10, seg=decode(0)=7'b1000000. Reset has priority over every other input.
//  - Edge detect: rise = hit & ~hit_q; hit_q <= hit every cycle in every state, including HOLD.
//  - Latency: a rise sampled at edge k updates ones/tens at edge k, visible from k onward
//    (one register stage). A hit held high for N cycles counts once.
//  - BCD increment: ones 9 -> 0 with tens+1; 99 + rise -> stay 99, ovf<=1, st<=OVF.
//  - FSM (priority clr > hold > rise, evaluated each edge):
//      RUN : clr -> count 00, stay RUN; hold -> HOLD; rise -> increment (or OVF at 99).
//      HOLD: clr -> count 00, ovf 0, RUN; !hold -> RUN; rises are dropped, not queued.
//      OVF : count frozen at 99; rises ignored; hold has no effect; clr -> 00, ovf 0, RUN.
//  - clr in any state also clears ovf. clr and rise in the same cycle -> result 00
//    (the rise is lost).
//  - hold and rise in the same cycle while in RUN -> HOLD, no increment.
//  - Scan: free-running counter 0..SCAN_DIV-1, runs in every state.
//      At terminal count: counter wraps to 0 and an toggles (10 <-> 01).
//      an=10 -> seg=decode(ones); an=01 -> seg=decode(tens). seg is registered with an,
//      so digit and segments always switch on the same edge.
//  - Decode: 0-9 use the standard common-anode patterns; codes 10-15 are unreachable but
//    decode to all-off 7'b1111111.
//  - Reset mid-count or mid-scan: all state returns to reset values on that edge, with no
//    partial digit carried over.
// STRUCTURE
//  - Package seq_pkg: state encodings ST_RUN/ST_HOLD/ST_OVF (2 bits), SEG_OFF constant,
//    BCD_MAX (4'd9).
//  - One sub-module: seg7_decode (combinational 4-bit BCD -> 7-bit active-low segments),
//    instanced once, fed by the digit mux.
//  - Top: edge detect, FSM + BCD counter, scan divider, output registers.
// TESTING (SCAN_DIV=4 for sim; clock 10 ns)
//  1 Reset: res=0 for 2 cycles, then 1
//    -> ones=0, tens=0, ovf=0, st=00, an=10, seg=7'b1000000.
//  2 12 single-cycle hit pulses spaced 2 cycles apart -> tens=1, ones=2;
//    hit high for 5 cycles -> exactly +1.
//  3 101 rises from 00 -> count 99, ovf=1, st=10 after the 100th; 101st rise changes
//    nothing; clr -> 00, ovf=0, st=00.
//  4 hold=1, 3 rises, hold=0 -> count unchanged, st 01 then 00;
//    rise with hold rising in the same cycle -> no increment.
//  5 clr and rise in the same cycle at count 07 -> count 00;
//    res=0 mid-scan with an=01 -> an=10, seg=decode(0) next edge.
//  6 count 42, observe 16 cycles -> an alternates every 4 cycles;
//    seg=7'b0011001 when an=01, 7'b0100100 when an=10.

Source files
------------

// File: rtl/seq_hit_counter_pkg.sv
// Shared encodings for the hit counter: FSM states, display constants, BCD limit.
package seq_pkg;
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HOLD = 2'b01,
        ST_OVF  = 2'b10
    } state_t;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;
endpackage

// File: rtl/seq_hit_counter_seg7_decode.sv
// BCD digit to active-low common-anode segments {g,f,e,d,c,b,a}; codes 10-15 blank.
module seg7_decode
    import seq_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_OFF;
        case (i_bcd)
            4'd0:    o_seg = 7'b1000000;
            4'd1:    o_seg = 7'b1111001;
            4'd2:    o_seg = 7'b0100100;
            4'd3:    o_seg = 7'b0110000;
            4'd4:    o_seg = 7'b0011001;
            4'd5:    o_seg = 7'b0010010;
            4'd6:    o_seg = 7'b0000010;
            4'd7:    o_seg = 7'b1111000;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0010000;
            default: o_seg = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seq_hit_counter.sv
// Counts rising edges of the detector hit in 2-digit BCD with sticky overflow,
// clear/hold control, and drives a scanned 2-digit active-low 7-segment display.
module seq_hit_counter
    import seq_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic       c,
    input  logic       res,
    input  logic       hit,
    input  logic       clr,
    input  logic       hold,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       ovf,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [1:0] st
);
    localparam int              SW        = $clog2(SCAN_DIV);
    localparam logic [SW-1:0]   SCAN_LAST = SW'(SCAN_DIV - 1);

    state_t        r_st;
    logic [3:0]    r_ones;
    logic [3:0]    r_tens;
    logic          r_ovf;
    logic          r_hit_q;
    logic [SW-1:0] r_scan;
    logic [1:0]    r_an;
    logic [6:0]    r_seg;

    state_t        w_st_nxt;
    logic [3:0]    w_ones_nxt;
    logic [3:0]    w_tens_nxt;
    logic          w_ovf_nxt;
    logic          w_rise;
    logic          w_scan_term;
    logic [1:0]    w_an_nxt;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg;

    assign w_rise = hit & ~r_hit_q;

    always_comb begin
        w_st_nxt   = r_st;
        w_ones_nxt = r_ones;
        w_tens_nxt = r_tens;
        w_ovf_nxt  = r_ovf;
        if (clr) begin
            w_st_nxt   = ST_RUN;
            w_ones_nxt = 4'd0;
            w_tens_nxt = 4'd0;
            w_ovf_nxt  = 1'b0;
        end else begin
            case (r_st)
                ST_RUN: begin
                    if (hold) begin
                        w_st_nxt = ST_HOLD;
                    end else if (w_rise) begin
                        if (r_ones == BCD_MAX && r_tens == BCD_MAX) begin
                            w_ovf_nxt = 1'b1;
                            w_st_nxt  = ST_OVF;
                        end else if (r_ones == BCD_MAX) begin
                            w_ones_nxt = 4'd0;
                            w_tens_nxt = r_tens + 4'd1;
                        end else begin
                            w_ones_nxt = r_ones + 4'd1;
                        end
                    end
                end
                ST_HOLD: if (!hold) w_st_nxt = ST_RUN;
                ST_OVF:  w_st_nxt = ST_OVF;
                default: w_st_nxt = ST_RUN;
            endcase
        end
    end

    // Segments decode the post-edge digit so they never lag the count or the anode.
    assign w_scan_term = (r_scan == SCAN_LAST);
    assign w_an_nxt    = w_scan_term ? ~r_an : r_an;
    assign w_digit     = (w_an_nxt == AN_UNITS) ? w_ones_nxt : w_tens_nxt;

    seg7_decode u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    always_ff @(posedge c) begin
        if (!res) begin
            r_st    <= ST_RUN;
            r_ones  <= 4'd0;
            r_tens  <= 4'd0;
            r_ovf   <= 1'b0;
            r_hit_q <= 1'b0;
            r_scan  <= '0;
            r_an    <= AN_UNITS;
            r_seg   <= SEG_ZERO;
        end else begin
            r_st    <= w_st_nxt;
            r_ones  <= w_ones_nxt;
            r_tens  <= w_tens_nxt;
            r_ovf   <= w_ovf_nxt;
            r_hit_q <= hit;
            r_scan  <= w_scan_term ? '0 : r_scan + SW'(1);
            r_an    <= w_an_nxt;
            r_seg   <= w_seg;
        end
    end

    assign ones = r_ones;
    assign tens = r_tens;
    assign ovf  = r_ovf;
    assign seg  = r_seg;
    assign an   = r_an;
    assign st   = r_st;
endmodule

// File: tb/tb_seq_hit_counter.sv
// Directed bench for seq_hit_counter with SCAN_DIV=4: table vectors plus hand sequences.
module tb_seq_hit_counter;
    localparam int SCAN = 4;

    logic       c, res, hit, clr, hold;
    logic [3:0] ones, tens;
    logic       ovf;
    logic [6:0] seg;
    logic [1:0] an, st;

    int checks = 0;
    int errors = 0;
    int since  = 0;

    typedef struct {
        logic       h, cl, hd;
        logic [3:0] eo, et;
        logic       eovf;
        logic [1:0] est;
        string      nm;
    } vec_t;
    vec_t vq[$];

    seq_hit_counter #(.SCAN_DIV(SCAN)) dut (
        .c(c), .res(res), .hit(hit), .clr(clr), .hold(hold),
        .ones(ones), .tens(tens), .ovf(ovf), .seg(seg), .an(an), .st(st)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Anode expected from edges elapsed since the last reset edge.
    function automatic logic [1:0] exp_an();
        return (((since / SCAN) % 2) == 0) ? 2'b10 : 2'b01;
    endfunction

    task step();
        @(posedge c);
        if (res == 1'b0) since = 0;
        else since++;
        #1;
    endtask

    task chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task chk_state(input string nm, input logic [3:0] eo, input logic [3:0] et,
                   input logic eovf, input logic [1:0] est);
        logic [1:0] ea;
        ea = exp_an();
        chk({nm, "/ones"}, 32'(ones), 32'(eo));
        chk({nm, "/tens"}, 32'(tens), 32'(et));
        chk({nm, "/ovf"},  32'(ovf),  32'(eovf));
        chk({nm, "/st"},   32'(st),   32'(est));
        chk({nm, "/an"},   32'(an),   32'(ea));
        chk({nm, "/seg"},  32'(seg),  32'(dec(ea == 2'b10 ? eo : et)));
    endtask

    task pulse();
        hit = 1'b1; step();
        hit = 1'b0; step();
    endtask

    task add(input logic h, input logic cl, input logic hd, input logic [3:0] eo,
             input logic [3:0] et, input logic eovf, input logic [1:0] est, input string nm);
        vec_t v;
        v.h = h; v.cl = cl; v.hd = hd; v.eo = eo; v.et = et;
        v.eovf = eovf; v.est = est; v.nm = nm;
        vq.push_back(v);
    endtask

    initial begin
        res = 1'b0; hit = 1'b0; clr = 1'b0; hold = 1'b0;

        // Table: hold behaviour from 13, then clr paths around count 07.
        add(0,0,1, 3,1,0,2'b01, "hold_enter");
        add(1,0,1, 3,1,0,2'b01, "hold_rise1");
        add(0,0,1, 3,1,0,2'b01, "hold_gap1");
        add(1,0,1, 3,1,0,2'b01, "hold_rise2");
        add(0,0,1, 3,1,0,2'b01, "hold_gap2");
        add(1,0,1, 3,1,0,2'b01, "hold_rise3");
        add(0,0,0, 3,1,0,2'b00, "hold_exit");
        add(1,0,1, 3,1,0,2'b01, "rise_with_hold");
        add(0,0,0, 3,1,0,2'b00, "hold_exit2");
        add(1,0,0, 4,1,0,2'b00, "run_rise");
        add(0,1,0, 0,0,0,2'b00, "clr");
        for (int i = 1; i <= 7; i++) begin
            add(1,0,0, 4'(i),0,0,2'b00, "to07_hi");
            add(0,0,0, 4'(i),0,0,2'b00, "to07_lo");
        end
        add(1,1,0, 0,0,0,2'b00, "clr_and_rise");
        add(0,1,1, 0,0,0,2'b00, "clr_and_hold");
        add(0,0,0, 0,0,0,2'b00, "idle");

        // Reset
        step(); step();
        chk_state("reset", 0, 0, 0, 2'b00);
        res = 1'b1;

        // Single pulses, carry, level hit
        for (int i = 1; i <= 12; i++) begin
            pulse();
            if (i == 10) chk_state("carry10", 0, 1, 0, 2'b00);
        end
        chk_state("pulse12", 2, 1, 0, 2'b00);
        hit = 1'b1;
        repeat (5) step();
        chk_state("level_high", 3, 1, 0, 2'b00);
        hit = 1'b0; step();
        chk_state("level_done", 3, 1, 0, 2'b00);

        foreach (vq[i]) begin
            hit = vq[i].h; clr = vq[i].cl; hold = vq[i].hd;
            step();
            chk_state(vq[i].nm, vq[i].eo, vq[i].et, vq[i].eovf, vq[i].est);
        end
        hit = 1'b0; clr = 1'b0; hold = 1'b0;

        // Overflow
        for (int i = 1; i <= 101; i++) begin
            pulse();
            if (i == 99)  chk_state("cnt99", 9, 9, 0, 2'b00);
            if (i == 100) chk_state("ovf100", 9, 9, 1, 2'b10);
            if (i == 101) chk_state("ovf101", 9, 9, 1, 2'b10);
        end
        hold = 1'b1; step();
        chk_state("ovf_hold", 9, 9, 1, 2'b10);
        hold = 1'b0; clr = 1'b1; step();
        chk_state("ovf_clr", 0, 0, 0, 2'b00);
        clr = 1'b0;

        // Reset while the tens digit is lit
        repeat (5) pulse();
        for (int k = 0; k < 2 * SCAN && exp_an() != 2'b01; k++) step();
        chk_state("pre_reset", 5, 0, 0, 2'b00);
        res = 1'b0; step();
        chk_state("reset_mid_scan", 0, 0, 0, 2'b00);
        res = 1'b1;

        // Scan observation at 42
        repeat (42) pulse();
        for (int k = 0; k < 16; k++) begin
            step();
            chk_state("scan42", 2, 4, 0, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
